sawtooth_monitor: RTL and testbench
===================================

// Module: sawtooth_monitor
// PURPOSE
//  Receive end of the sawtooth sample stream. Accepts one WIDTH-bit sample per
//  valid cycle and checks that each is the previous sample + 1 mod 2^WIDTH.
//  Reports lock, wrap events, measured period (samples per ramp) and step
//  errors. Sits downstream of the sawtooth generator, on-board or in simulation.
// PARAMETERS
//  WIDTH       8   sample width; ramp modulus 2^WIDTH
//  LOCK_COUNT  4   consecutive good steps needed to declare lock (>=1)
//  PERIOD_W    16  period/err counter width; must be >= WIDTH+1
// PORTS
//  clk          in   1         system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  sample_valid in   1         sample qualifier; one sample accepted per high cycle
//  sample       in   WIDTH     incoming waveform sample
//  locked       out  1         high while state==LOCKED
//  wrap_pulse   out  1         1-cycle pulse: accepted good step max->0
//  period       out  PERIOD_W  samples between last two wraps; held between updates
//  period_valid out  1         1-cycle pulse when period updated
//  err_pulse    out  1         1-cycle pulse: bad step while LOCKED
//  err_count    out  PERIOD_W  number of lock losses, saturating at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0; prev, good_cnt,
//   samp_cnt, wrap_seen = 0.
//  All outputs registered: response appears the cycle after sample accepted.
//  sample_valid low: no state, counter or output change; pulses drop to 0.
//  good step: sample == prev+1 truncated to WIDTH (max -> 0 is good).
//  prev <= sample on every accepted sample, in every state.
//  FSM:
//   IDLE: first accepted sample -> ACQUIRE, good_cnt=0; no check performed.
//   ACQUIRE: good step -> good_cnt+1; reaching LOCK_COUNT -> LOCKED, wrap_seen=0.
//            bad step -> good_cnt=0, stay. No err_pulse in ACQUIRE.
//   LOCKED: good step -> stay. bad step -> err_pulse, err_count+1 (sat),
//           -> ACQUIRE, good_cnt=0, wrap_seen=0.
//  Wrap/period (any state except IDLE):
//   good step with sample==0 -> wrap_pulse; samp_cnt <= 1.
//   other accepted sample -> samp_cnt+1, saturating at all-ones.
//   on wrap in LOCKED with wrap_seen=1 -> period<=samp_cnt, period_valid pulse.
//   on wrap in LOCKED -> wrap_seen<=1. Wrap step that completes lock counts as
//   a wrap seen in LOCKED.
//  Clean ramp: period = 2^WIDTH.
//  Simultaneous: bad step in LOCKED is never a wrap; err_pulse and wrap_pulse
//   never both high.
//  rst_n low mid-stream: immediate clear; relock needs 1+LOCK_COUNT samples.
// TESTING
//  1 Reset, then clean ramp 0..255 continuous (WIDTH=8) -> locked high the cycle
//    after 5th sample; err_pulse never; err_count=0.
//  2 Continuous ramp through 3 wraps -> wrap_pulse at each 255->0; first
//    period_valid at 2nd wrap after lock, period=256; period holds in between.
//  3 Locked, inject sample 77 where 40 expected -> err_pulse 1 cycle, err_count=1,
//    locked low; relock after 4 good steps following 78.
//  4 sample_valid toggled 1-of-3 cycles on clean ramp -> same lock/period results
//    as test 2; outputs static on invalid cycles.
//  5 Assert rst_n low mid-ramp while locked -> all outputs 0 asynchronously (before
//    next clk edge); after release, IDLE then relock after 5 samples.
//  6 Feed constant 0x00 -> never locks, no err_pulse, err_count stays 0.

Source files
------------

// File: rtl/sawtooth_monitor.sv
`default_nettype none
// ============================================================================
// sawtooth_monitor : checks a +1 ramp stream; reports lock, wraps, period, errors
// Revision: 1.0
// ============================================================================
module sawtooth_monitor #(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int PERIOD_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_valid,
   input  logic [WIDTH-1:0]    sample,
   output logic                locked,
   output logic                wrap_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                err_pulse,
   output logic [PERIOD_W-1:0] err_count
);
   localparam int                GOOD_W      = $clog2(LOCK_COUNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [1:0]          rst_sync;
   logic                rst_int_n;
   logic [WIDTH-1:0]    prev;
   logic [GOOD_W-1:0]   good_cnt, good_cnt_nxt;
   logic [PERIOD_W-1:0] samp_cnt, samp_cnt_nxt;
   logic [PERIOD_W-1:0] period_nxt, err_count_nxt;
   logic                wrap_seen, wrap_seen_nxt;
   logic                wrap_nxt, period_valid_nxt, err_nxt;
   logic                good_step, wrap_step;

   // Assertion is immediate; release is synchronised so all state leaves reset together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   assign good_step = (sample == prev + WIDTH'(1));
   assign wrap_step = good_step && (sample == '0) && (state != IDLE);
   assign locked    = (state == LOCKED);

   always_comb begin
      state_nxt        = state;
      good_cnt_nxt     = good_cnt;
      samp_cnt_nxt     = samp_cnt;
      wrap_seen_nxt    = wrap_seen;
      period_nxt       = period;
      err_count_nxt    = err_count;
      wrap_nxt         = 1'b0;
      period_valid_nxt = 1'b0;
      err_nxt          = 1'b0;
      if (sample_valid) begin
         if (state != IDLE) begin
            wrap_nxt = wrap_step;
            if (wrap_step)             samp_cnt_nxt = PERIOD_W'(1);
            else if (samp_cnt != '1)   samp_cnt_nxt = samp_cnt + PERIOD_W'(1);
         end
         case (state)
            IDLE: begin
               state_nxt    = ACQUIRE;
               good_cnt_nxt = '0;
            end
            ACQUIRE: begin
               if (good_step) begin
                  good_cnt_nxt = good_cnt + GOOD_W'(1);
                  // a wrap on the locking step counts as the first wrap seen in lock
                  if (good_cnt_nxt == GOOD_TARGET) begin
                     state_nxt     = LOCKED;
                     wrap_seen_nxt = wrap_step;
                  end
               end else begin
                  good_cnt_nxt = '0;
               end
            end
            LOCKED: begin
               if (good_step) begin
                  if (wrap_step) begin
                     wrap_seen_nxt = 1'b1;
                     if (wrap_seen) begin
                        period_nxt       = samp_cnt;
                        period_valid_nxt = 1'b1;
                     end
                  end
               end else begin
                  err_nxt = 1'b1;
                  if (err_count != '1) err_count_nxt = err_count + PERIOD_W'(1);
                  state_nxt     = ACQUIRE;
                  good_cnt_nxt  = '0;
                  wrap_seen_nxt = 1'b0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state        <= IDLE;
         prev         <= '0;
         good_cnt     <= '0;
         samp_cnt     <= '0;
         wrap_seen    <= 1'b0;
         period       <= '0;
         err_count    <= '0;
         wrap_pulse   <= 1'b0;
         period_valid <= 1'b0;
         err_pulse    <= 1'b0;
      end else begin
         state        <= state_nxt;
         good_cnt     <= good_cnt_nxt;
         samp_cnt     <= samp_cnt_nxt;
         wrap_seen    <= wrap_seen_nxt;
         period       <= period_nxt;
         err_count    <= err_count_nxt;
         wrap_pulse   <= wrap_nxt;
         period_valid <= period_valid_nxt;
         err_pulse    <= err_nxt;
         if (sample_valid) prev <= sample;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sawtooth_monitor.sv
`default_nettype none
// tb_sawtooth_monitor : scoreboard bench; a behavioural model queues expected outputs per cycle.
module tb_sawtooth_monitor;
   localparam int LOCK_COUNT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sample_valid = 1'b0;
   logic [7:0]  sample = 8'd0;
   logic        locked, wrap_pulse, period_valid, err_pulse;
   logic [15:0] period, err_count;

   typedef struct packed {
      logic        lck;
      logic        wrp;
      logic [15:0] per;
      logic        pv;
      logic        err;
      logic [15:0] errc;
   } obs_t;

   obs_t observed, expected;
   obs_t sb[$];
   int   n_vec = 0, n_bad = 0;
   int   m_state, m_prev, m_good, m_samp, m_ws, m_period, m_errc;
   logic m_wrap, m_pv, m_err;

   always #5 clk = ~clk;

   sawtooth_monitor #(.WIDTH(8), .LOCK_COUNT(LOCK_COUNT), .PERIOD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
      .locked(locked), .wrap_pulse(wrap_pulse), .period(period),
      .period_valid(period_valid), .err_pulse(err_pulse), .err_count(err_count)
   );

   assign observed = {locked, wrap_pulse, period, period_valid, err_pulse, err_count};

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_good = 0; m_samp = 0; m_ws = 0; m_period = 0; m_errc = 0;
      sb.delete();
   endtask

   task automatic model_step(input logic v, input logic [7:0] s);
      logic good, wrap;
      obs_t e;
      m_wrap = 1'b0; m_pv = 1'b0; m_err = 1'b0;
      if (v) begin
         good = (s == 8'(m_prev + 1));
         if (m_state == 0) begin
            m_state = 1; m_good = 0;
         end else begin
            wrap = good && (s == 8'd0);
            m_wrap = wrap;
            if (m_state == 2 && wrap && m_ws != 0) begin m_period = m_samp; m_pv = 1'b1; end
            m_samp = wrap ? 1 : ((m_samp == 65535) ? 65535 : m_samp + 1);
            if (m_state == 1) begin
               if (good) begin
                  m_good++;
                  if (m_good == LOCK_COUNT) begin m_state = 2; m_ws = wrap ? 1 : 0; end
               end else m_good = 0;
            end else if (good) begin
               if (wrap) m_ws = 1;
            end else begin
               m_err = 1'b1; m_state = 1; m_good = 0; m_ws = 0;
               if (m_errc < 65535) m_errc++;
            end
         end
         m_prev = s;
      end
      e = {(m_state == 2), m_wrap, 16'(m_period), m_pv, m_err, 16'(m_errc)};
      sb.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [7:0] s);
      @(negedge clk);
      sample_valid = v;
      sample       = s;
      model_step(v, s);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      sample_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (observed !== '0) begin n_bad++; $display("FAIL reset_state got %h exp %h", observed, obs_t'('0)); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'($urandom));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL reset_idle i=%0d got %h exp %h", i, observed, expected); end
      end
   endtask

   task automatic test_clean_ramp();
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 8'(i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL clean_ramp i=%0d got %h exp %h", i, observed, expected); end
         if (i == 3) begin n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL early_lock got %b exp 0", locked); end end
         if (i == 4) begin n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock_5th got %b exp 1", locked); end end
      end
      n_vec++;
      if (err_count !== 16'd0) begin n_bad++; $display("FAIL ramp_errc got %0d exp 0", err_count); end
   endtask

   task automatic test_wraps();
      int n_pv = 0, n_wrap = 0;
      for (int i = 0; i < 768; i++) begin
         drive(1'b1, 8'(i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL wraps i=%0d got %h exp %h", i, observed, expected); end
         if (wrap_pulse === 1'b1) n_wrap++;
         if (period_valid === 1'b1) begin
            n_pv++; n_vec++;
            if (period !== 16'd256) begin n_bad++; $display("FAIL wraps_period got %0d exp 256", period); end
         end
      end
      n_vec++;
      if (n_wrap != 3 || n_pv != 2) begin n_bad++; $display("FAIL wraps_count got wrap=%0d pv=%0d exp wrap=3 pv=2", n_wrap, n_pv); end
   endtask

   task automatic test_step_error();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'(i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL err_pre i=%0d got %h exp %h", i, observed, expected); end
      end
      drive(1'b1, 8'd77);
      expected = sb.pop_front(); n_vec++;
      if (observed !== expected) begin n_bad++; $display("FAIL err_inject got %h exp %h", observed, expected); end
      n_vec++;
      if ({err_pulse, locked, err_count} !== {1'b1, 1'b0, 16'd1}) begin
         n_bad++; $display("FAIL err_flags got p=%b l=%b c=%0d exp p=1 l=0 c=1", err_pulse, locked, err_count);
      end
      for (int i = 78; i < 86; i++) begin
         drive(1'b1, 8'(i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL err_relock i=%0d got %h exp %h", i, observed, expected); end
      end
      n_vec++;
      if ({locked, err_pulse, err_count} !== {1'b1, 1'b0, 16'd1}) begin
         n_bad++; $display("FAIL err_after got l=%b p=%b c=%0d exp l=1 p=0 c=1", locked, err_pulse, err_count);
      end
   endtask

   task automatic test_sparse_valid();
      int n_pv = 0, n_wrap = 0;
      do_reset();
      for (int i = 0; i < 1024; i++) begin
         drive(1'b1, 8'(i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL sparse i=%0d got %h exp %h", i, observed, expected); end
         if (wrap_pulse === 1'b1) n_wrap++;
         if (period_valid === 1'b1) begin
            n_pv++; n_vec++;
            if (period !== 16'd256) begin n_bad++; $display("FAIL sparse_period got %0d exp 256", period); end
         end
         for (int k = 0; k < 2; k++) begin
            drive(1'b0, 8'($urandom));
            expected = sb.pop_front(); n_vec++;
            if (observed !== expected) begin n_bad++; $display("FAIL sparse_idle i=%0d got %h exp %h", i, observed, expected); end
         end
      end
      n_vec++;
      if (n_wrap != 3 || n_pv != 2) begin n_bad++; $display("FAIL sparse_count got wrap=%0d pv=%0d exp wrap=3 pv=2", n_wrap, n_pv); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL arst_pre i=%0d got %h exp %h", i, observed, expected); end
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (observed !== '0) begin n_bad++; $display("FAIL arst_clear got %h exp %h", observed, obs_t'('0)); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(100 + i));
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL arst_relock i=%0d got %h exp %h", i, observed, expected); end
         if (i == 3) begin n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_early got %b exp 0", locked); end end
         if (i == 4) begin n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL arst_lock got %b exp 1", locked); end end
      end
   endtask

   task automatic test_constant();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'h00);
         expected = sb.pop_front(); n_vec++;
         if (observed !== expected) begin n_bad++; $display("FAIL const i=%0d got %h exp %h", i, observed, expected); end
      end
      n_vec++;
      if ({locked, err_pulse, err_count} !== 18'd0) begin
         n_bad++; $display("FAIL const_final got l=%b p=%b c=%0d exp all 0", locked, err_pulse, err_count);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_ramp();
      test_wraps();
      test_step_error();
      test_sparse_valid();
      test_async_reset();
      test_constant();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
